// File: rtl/serial_pkg.sv
// Shared types and constants for the serial deframer.
package serial_pkg;

  typedef enum logic [1:0] {
    StHunt,
    StData,
    StCheck
  } state_e;

  localparam int unsigned DefWidth    = 8;
  localparam logic [7:0]  DefSyncWord = 8'hA5;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_deframer_if.sv
// Serial input and word output bundle of the deframer.
interface serial_deframer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             din;
  logic             din_en;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             locked;
  logic             sync_err;
  logic             overflow;
  logic             clear_ovf;

  modport slave (
    input  din, din_en, word_ready, clear_ovf,
    output word_out, word_valid, locked, sync_err, overflow
  );

  modport master (
    output din, din_en, word_ready, clear_ovf,
    input  word_out, word_valid, locked, sync_err, overflow
  );

endinterface

// File: rtl/word_fifo2.sv
// Two-entry synchronous FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module word_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       level;
  logic             pop_eff, push_eff;

  // Next occupancy and contents: apply the pop first, then append the push.
  always_comb begin
    mem_d    = mem_q;
    pop_eff  = pop_i && (cnt_q != 2'd0);
    push_eff = push_i && ((cnt_q != 2'd2) || pop_eff);
    level    = cnt_q - {1'b0, pop_eff};
    if (pop_eff) begin
      mem_d[0] = mem_q[1];
    end
    if (push_eff) begin
      mem_d[level[0]] = data_i;
    end
    cnt_d = level + {1'b0, push_eff};
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = mem_q[0];

endmodule

// File: rtl/serial_deframer.sv
// Hunts a sync word in a serial stream, packs the following bits into words and
// re-checks sync after every frame of FRAME_WORDS words.
module serial_deframer
  import serial_pkg::*;
#(
  parameter int unsigned      WIDTH       = DefWidth,
  parameter logic [WIDTH-1:0] SYNC_WORD   = DefSyncWord,
  parameter int unsigned      FRAME_WORDS = 4
) (
  input logic               clk,
  input logic               rst,
  serial_deframer_if.slave  bus
);

  localparam int unsigned      BitW     = cnt_w(WIDTH);
  localparam int unsigned      WordW    = cnt_w(FRAME_WORDS);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WIDTH - 1);
  localparam logic [BitW-1:0]  BitOne   = BitW'(1);
  localparam logic [WordW-1:0] WordLast = WordW'(FRAME_WORDS - 1);
  localparam logic [WordW-1:0] WordOne  = WordW'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sr_q, sr_d, nxt;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic [WordW-1:0]  wordcnt_q, wordcnt_d;
  logic              locked_q, locked_d;
  logic              sync_err_q, sync_err_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, full, empty;

  // Framing FSM, counters and sticky overflow next-state.
  always_comb begin
    nxt        = {sr_q[WIDTH-2:0], bus.din};
    sr_d       = bus.din_en ? nxt : sr_q;
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    wordcnt_d  = wordcnt_q;
    sync_err_d = 1'b0;
    push       = 1'b0;
    if (bus.din_en) begin
      unique case (state_q)
        StHunt: begin
          if (nxt == SYNC_WORD) begin
            state_d   = StData;
            bitcnt_d  = '0;
            wordcnt_d = '0;
          end
        end
        StData: begin
          if (bitcnt_q == BitLast) begin
            push     = 1'b1;
            bitcnt_d = '0;
            if (wordcnt_q == WordLast) begin
              state_d = StCheck;
            end else begin
              wordcnt_d = wordcnt_q + WordOne;
            end
          end else begin
            bitcnt_d = bitcnt_q + BitOne;
          end
        end
        StCheck: begin
          if (bitcnt_q == BitLast) begin
            bitcnt_d = '0;
            if (nxt == SYNC_WORD) begin
              state_d   = StData;
              wordcnt_d = '0;
            end else begin
              state_d    = StHunt;
              sync_err_d = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + BitOne;
          end
        end
        default: state_d = StHunt;
      endcase
    end
    locked_d = (state_d == StData) || (state_d == StCheck);
    // A new drop beats a same-cycle clear.
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end else if (bus.clear_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State, shift register, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StHunt;
      sr_q       <= '0;
      bitcnt_q   <= '0;
      wordcnt_q  <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bitcnt_q   <= bitcnt_d;
      wordcnt_q  <= wordcnt_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

  assign pop = bus.word_ready && !empty;

  word_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (nxt),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (bus.word_out)
  );

  assign bus.word_valid = !empty;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: table vectors, hand sequences and a randomized run
// against a frame-position reference model.
module tb_serial_deframer;

  localparam logic [7:0] Sync = 8'hA5;
  localparam int         Fw   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_deframer_if #(.WIDTH(8)) bus ();

  serial_deframer #(
    .WIDTH       (8),
    .SYNC_WORD   (Sync),
    .FRAME_WORDS (Fw)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: bit history, position within the locked frame, word queue.
  logic [7:0] m_hist;
  bit         m_locked;
  int         m_pos;
  logic [7:0] m_q[$];
  bit         m_ovf;
  bit         m_err;

  typedef struct {
    logic [7:0] b;
    logic       lk;
    logic       vld;
    logic [7:0] w;
    logic       err;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist   = 8'h00;
    m_locked = 1'b0;
    m_pos    = 0;
    m_q.delete();
    m_ovf    = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input logic d, input logic e, input logic r, input logic c);
    bit         pop, push, drop;
    logic [7:0] w;
    pop   = r && (m_q.size() > 0);
    push  = 1'b0;
    w     = 8'h00;
    m_err = 1'b0;
    if (e) begin
      m_hist = {m_hist[6:0], d};
      if (!m_locked) begin
        if (m_hist == Sync) begin
          m_locked = 1'b1;
          m_pos    = 0;
        end
      end else if (m_pos % 8 != 7) begin
        m_pos++;
      end else if (m_pos / 8 < Fw) begin
        push = 1'b1;
        w    = m_hist;
        m_pos++;
      end else if (m_hist == Sync) begin
        m_pos = 0;
      end else begin
        m_locked = 1'b0;
        m_err    = 1'b1;
      end
    end
    if (pop) void'(m_q.pop_front());
    drop = push && (m_q.size() == 2);
    if (push && !drop) m_q.push_back(w);
    m_ovf = drop || (m_ovf && !c);
  endtask

  task automatic compare_model();
    chk("m_locked", {7'd0, bus.locked}, {7'd0, m_locked});
    chk("m_sync_err", {7'd0, bus.sync_err}, {7'd0, m_err});
    chk("m_overflow", {7'd0, bus.overflow}, {7'd0, m_ovf});
    chk("m_valid", {7'd0, bus.word_valid}, {7'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) chk("m_word", bus.word_out, m_q[0]);
  endtask

  // One clock: drive inputs, advance the model, check at the falling edge.
  task automatic cyc(input logic d, input logic e, input logic r, input logic c);
    bus.din        = d;
    bus.din_en     = e;
    bus.word_ready = r;
    bus.clear_ovf  = c;
    model_step(d, e, r, c);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    #2;
    bus.din = 1'b0; bus.din_en = 1'b0; bus.word_ready = 1'b0; bus.clear_ovf = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_word", bus.word_out, 8'h00);
    chk("rst_valid", {7'd0, bus.word_valid}, 8'h00);
    chk("rst_locked", {7'd0, bus.locked}, 8'h00);
    chk("rst_err", {7'd0, bus.sync_err}, 8'h00);
    chk("rst_ovf", {7'd0, bus.overflow}, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Bits MSB first; gap idle cycles before each strobe.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic r);
    for (int i = 7; i >= 0; i--) begin
      repeat (gap) cyc(1'b0, 1'b0, r, 1'b0);
      cyc(b[i], 1'b1, r, 1'b0);
    end
  endtask

  task automatic run_table(input int gap);
    logic [2:0] pre;
    pre = 3'b011;
    do_reset();
    for (int i = 2; i >= 0; i--) begin
      repeat (gap) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(pre[i], 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 13; i++) begin
      send_byte(tv[i].b, gap, 1'b1);
      chk($sformatf("tv%0d_g%0d_locked", i, gap), {7'd0, bus.locked}, {7'd0, tv[i].lk});
      chk($sformatf("tv%0d_g%0d_valid", i, gap), {7'd0, bus.word_valid}, {7'd0, tv[i].vld});
      chk($sformatf("tv%0d_g%0d_err", i, gap), {7'd0, bus.sync_err}, {7'd0, tv[i].err});
      if (tv[i].vld) chk($sformatf("tv%0d_g%0d_word", i, gap), bus.word_out, tv[i].w);
    end
  endtask

  int cyc_cnt;
  int rst_at;

  task automatic rcyc(input logic d, input logic e, input logic r, input logic c);
    cyc(d, e, r, c);
    cyc_cnt++;
    if (cyc_cnt == rst_at) do_reset();
  endtask

  task automatic rsend(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      while ($urandom_range(0, 2) == 0)
        rcyc(1'($urandom), 1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      rcyc(b[i], 1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] w77;
    tv[0]  = '{8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[1]  = '{8'h12, 1'b1, 1'b1, 8'h12, 1'b0};
    tv[2]  = '{8'h34, 1'b1, 1'b1, 8'h34, 1'b0};
    tv[3]  = '{8'h56, 1'b1, 1'b1, 8'h56, 1'b0};
    tv[4]  = '{8'h78, 1'b1, 1'b1, 8'h78, 1'b0};
    tv[5]  = '{8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[6]  = '{8'h9A, 1'b1, 1'b1, 8'h9A, 1'b0};
    tv[7]  = '{8'hBC, 1'b1, 1'b1, 8'hBC, 1'b0};
    tv[8]  = '{8'hDE, 1'b1, 1'b1, 8'hDE, 1'b0};
    tv[9]  = '{8'hF0, 1'b1, 1'b1, 8'hF0, 1'b0};
    tv[10] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    tv[11] = '{8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[12] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0};

    bus.din = 1'b0; bus.din_en = 1'b0; bus.word_ready = 1'b0; bus.clear_ovf = 1'b0;
    model_reset();
    @(negedge clk);

    // Lock, delivery, sync failure and relock; then the same with a sparse strobe.
    run_table(0);
    run_table(2);

    // Backpressure: third word dropped, then drain and clear.
    do_reset();
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    send_byte(8'h33, 0, 1'b0);
    chk("bp_ovf", {7'd0, bus.overflow}, 8'h01);
    chk("bp_head", bus.word_out, 8'h11);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_second", bus.word_out, 8'h22);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_empty", {7'd0, bus.word_valid}, 8'h00);
    chk("bp_ovf_held", {7'd0, bus.overflow}, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_ovf_clr", {7'd0, bus.overflow}, 8'h00);
    send_byte(8'h44, 0, 1'b1);
    send_byte(8'hA5, 0, 1'b1);

    // Full buffer with a pop on the exact edge the third word completes.
    send_byte(8'h55, 0, 1'b0);
    send_byte(8'h66, 0, 1'b0);
    w77 = 8'h77;
    for (int i = 7; i >= 1; i--) cyc(w77[i], 1'b1, 1'b0, 1'b0);
    chk("fp_head0", bus.word_out, 8'h55);
    cyc(w77[0], 1'b1, 1'b1, 1'b0);
    chk("fp_no_ovf", {7'd0, bus.overflow}, 8'h00);
    chk("fp_head1", bus.word_out, 8'h66);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fp_head2", bus.word_out, 8'h77);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("fp_empty", {7'd0, bus.word_valid}, 8'h00);

    // Randomized framed traffic with one asynchronous reset mid-stream.
    do_reset();
    cyc_cnt = 0;
    rst_at  = $urandom_range(300, 1500);
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 3) == 0) rsend(8'($urandom));
      b = Sync;
      if ($urandom_range(0, 4) == 0) begin
        b = 8'($urandom);
        if (b == Sync) b = 8'h3C;
      end
      rsend(b);
      for (int k = 0; k < Fw; k++) rsend(8'($urandom));
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_deframer.md
# serial_deframer

Downstream consumer of the serial shift-register chain. It takes the serial bit stream leaving the last flop stage, hunts for a sync word, and assembles the following bits into parallel data words. Completed words go into a 2-entry output buffer with a valid/ready handshake. It re-checks sync after every frame and drops back to hunting when the sync check fails.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits; also the width of the sync word (minimum 2).
- `SYNC_WORD`, default 8'hA5: sync pattern, `WIDTH` bits, MSB first on the wire.
- `FRAME_WORDS`, default 4: data words per frame between sync words (minimum 1).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (assert low, release high).
- `din`  in  1  serial data bit.
- `din_en`  in  1  bit strobe; `din` is sampled only when this is high.
- `word_out`  out  WIDTH  head-of-buffer data word, MSB = first received bit.
- `word_valid`  out  1  buffer is not empty.
- `word_ready`  in  1  consumer accepts `word_out` when `word_valid` and `word_ready` are both high.
- `locked`  out  1  high in the DATA and CHECK states.
- `sync_err`  out  1  one-cycle pulse when a CHECK fails.
- `overflow`  out  1  sticky; set when a completed word is dropped.
- `clear_ovf`  in  1  synchronous clear of `overflow`.

## Operation
Shift register:
- On every `din_en`, `sr <= {sr[WIDTH-2:0], din}`.
- The shift register operates in all states.
- `nxt` is the value of `sr` after the current shift.

Bit counter:
- `bitcnt` counts from 0 to WIDTH-1 and advances only on `din_en`.
- It is cleared on entry to DATA.

Word counter:
- `wordcnt` counts from 0 to FRAME_WORDS-1.

States:
- HUNT: on `din_en` with `nxt == SYNC_WORD`, go to DATA and clear `bitcnt` and `wordcnt`. Matching is bit-by-bit, so a sync word straddling earlier garbage is still found.
- DATA:
  - On `din_en` with `bitcnt == WIDTH-1`, push `nxt` into the buffer and increment `wordcnt`.
  - If `wordcnt == FRAME_WORDS-1`, go to CHECK and clear `bitcnt`.
- CHECK:
  - On `din_en` with `bitcnt == WIDTH-1`:
    - If `nxt == SYNC_WORD`, go to DATA and clear `wordcnt`.
    - Otherwise pulse `sync_err` and go to HUNT.
  - Nothing is pushed in this state.

Buffer (2 entries, FIFO order):
- Push with the buffer not full: the word is stored.
- Push with the buffer full and no pop in the same cycle: the word is dropped and `overflow` is set.
- Push with the buffer full and a pop in the same cycle: the word is stored, the pop frees the slot, and no overflow occurs.
- Pop with the buffer empty: ignored.
- `clear_ovf` in the same cycle as a new overflow: set wins.

Reset (`rst` low):
- State goes to HUNT.
- `sr`, counters and buffer are cleared.
- All outputs are 0: `word_out`=0, `word_valid`=0, `locked`=0, `sync_err`=0, `overflow`=0.
- Reset mid-frame discards the partial word and all buffered words.

## Timing
- Sync match on the edge where `din_en` samples the last sync bit: `locked` goes high on the next cycle.
- Last data bit sampled on edge N: `word_valid` is high from cycle N+1 when the buffer was empty; `word_out` is stable from the same cycle.
- Throughput:
  - Up to one bit per clock.
  - With `din_en` held high, a word completes every WIDTH cycles.
  - The consumer may stall indefinitely; data is lost only through overflow.
- `word_out`/`word_valid` hold steady while `word_valid` is high and `word_ready` is low.
- Pop on edge M: the second entry appears on `word_out` in cycle M+1, or `word_valid` drops if the buffer held one entry.
- `sync_err` is high for exactly one cycle, coincident with the first cycle `locked` is low.
- A cycle with `din_en` low changes nothing except buffer pops and `overflow` clearing.

## Structure
- Package `serial_pkg`:
  - state enum (HUNT, DATA, CHECK)
  - default `WIDTH` and `SYNC_WORD` constants
  - counter-width helper based on $clog2
- Sub-module `word_fifo2`:
  - 2-entry synchronous FIFO, parameterized by `WIDTH`
  - ports: push, data, pop, full, empty, head
  - same clock and reset scheme as this block
- Top level holds the shift register, counters, FSM and overflow flag.

## Test plan
Defaults for all scenarios: WIDTH=8, SYNC_WORD=8'hA5, FRAME_WORDS=4; `din_en` high continuously unless noted.

1. Reset mid-stream: drive `rst` low for 1 cycle at a random point.
   - Required: every output 0 immediately (asynchronous).
   - Required: after release, no word until a fresh A5 is seen.
2. Basic lock:
   - Stimulus: bits 0,1,1 then A5, 12, 34, 56, 78, A5, with `word_ready`=1.
   - Required: `locked` high 1 cycle after the first A5's last bit.
   - Required: words 12, 34, 56, 78 appear in order, each `word_valid` high for 1 cycle.
   - Required: still locked after the second A5.
3. Sync failure:
   - Stimulus: A5, 4 data words, then 3C in the sync slot.
   - Required: `sync_err` pulses once, `locked` drops, 3C is not delivered, and the block relocks on the next A5.
4. Backpressure and overflow:
   - Stimulus: `word_ready`=0 while locked and sending 11, 22, 33.
   - Required: buffer holds 11 then 22; 33 is dropped; `overflow`=1.
   - Then `word_ready`=1. Required: 11 then 22 are delivered.
   - Then `clear_ovf`=1 for 1 cycle. Required: `overflow`=0.
5. Full buffer with simultaneous pop:
   - Stimulus: buffer full, `word_ready` asserted in the exact cycle the third word completes.
   - Required: no overflow; all three words delivered in order.
6. Sparse strobe: `din_en` high once every 3 cycles, same stream as scenario 2.
   - Required: identical delivered words.
   - Required: `word_valid` rises 1 cycle after each last-bit strobe.
